// File: rtl/sig_fmt_pkg.sv
// sig_fmt_pkg: shared constants, FSM states and FIFO entry layout for the signature formatter
package sig_fmt_pkg;
  localparam logic [255:0] SECP256K1_N      = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
  localparam logic [255:0] SECP256K1_HALF_N = 256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_5D576E73_57A4501D_DFE92F46_681B20A0;
  localparam int V_LEGACY_BASE   = 27;
  localparam int V_EIP155_OFFSET = 35;
  localparam int ERR_R     = 0;
  localparam int ERR_S     = 1;
  localparam int ERR_RECID = 2;
  typedef enum logic [1:0] {IDLE, NORM, CHECK, PUSH} fmt_state_t;
  typedef struct packed {
    logic [255:0] r;
    logic [255:0] s;
    logic [255:0] hash;
    logic [2:0]   err;
  } sig_entry_t;
endpackage

// File: rtl/sig_fmt_fifo.sv
// sig_fmt_fifo: synchronous first-word-fall-through FIFO with occupancy count
module sig_fmt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [W-1:0]             din,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          wr, rd;
  assign rd_valid = count != '0;
  assign wr_ready = count != (AW+1)'(DEPTH) || rd_ready;
  assign rd       = rd_valid && rd_ready;
  assign wr       = wr_valid && wr_ready;
  assign dout     = rd_valid ? mem[rp] : '0;
  // storage needs no reset; an empty count masks stale words
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/sig_output_formatter.sv
// sig_output_formatter: low-s normalise, range-check and v-encode signatures into an output FIFO (SIG_STATS_EN adds pop statistics)
module sig_output_formatter
  import sig_fmt_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int V_W      = 32,
  parameter int CHAIN_ID = 11155111
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [255:0]             in_r,
  input  logic [255:0]             in_s,
  input  logic [1:0]               in_recid,
  input  logic [255:0]             in_hash,
  input  logic                     eip155,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [255:0]             out_r,
  output logic [255:0]             out_s,
  output logic [V_W-1:0]           out_v,
  output logic [255:0]             out_hash,
  output logic [2:0]               out_err,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef SIG_STATS_EN
  ,
  output logic [31:0]              stat_ok,
  output logic [31:0]              stat_err
`endif
);
  localparam logic [V_W-1:0] V_EIP_BASE = V_W'(CHAIN_ID * 2 + V_EIP155_OFFSET);
  localparam logic [V_W-1:0] V_LEG_BASE = V_W'(V_LEGACY_BASE);
  fmt_state_t     state, state_nx;
  logic [255:0]   r_q, s_q, hash_q;
  logic [1:0]     recid_q;
  logic           eip_q;
  logic [2:0]     err_q;
  logic [V_W-1:0] v_q;
  logic           rerr, serr, wr_ready;
  sig_entry_t     head;
  assign rerr = r_q == '0 || r_q >= SECP256K1_N;
  assign serr = s_q == '0 || s_q >= SECP256K1_N;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // next state and handshake; in_ready is held low while rst is asserted
  always_comb begin
    in_ready = state == IDLE && !rst;
    state_nx = state == IDLE  ? (in_valid && in_ready ? NORM : IDLE) :
               state == NORM  ? CHECK :
               state == CHECK ? PUSH :
               wr_ready       ? IDLE : PUSH;
  end
  // datapath: capture, low-s normalisation with recid flip, v encoding
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      r_q     <= in_r;
      s_q     <= in_s;
      hash_q  <= in_hash;
      recid_q <= in_recid;
      eip_q   <= eip155;
    end
    if (state == NORM) begin
      err_q <= {recid_q > 2'd1, serr, rerr};
      if (!serr && s_q > SECP256K1_HALF_N) begin
        s_q        <= SECP256K1_N - s_q;
        recid_q[0] <= ~recid_q[0];
      end
    end
    if (state == CHECK) v_q <= (eip_q ? V_EIP_BASE : V_LEG_BASE) + V_W'(recid_q[0]);
  end
  sig_fmt_fifo #(.DEPTH(DEPTH), .W(V_W + $bits(sig_entry_t))) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (state == PUSH),
    .wr_ready (wr_ready),
    .din      ({v_q, r_q, s_q, hash_q, err_q}),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .dout     ({out_v, head}),
    .count    (fifo_count)
  );
  assign out_r    = head.r;
  assign out_s    = head.s;
  assign out_hash = head.hash;
  assign out_err  = head.err;
`ifdef SIG_STATS_EN
  // saturating counts of popped clean and flagged entries
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ok  <= '0;
      stat_err <= '0;
    end else if (out_valid && out_ready) begin
      if (out_err == '0) stat_ok <= stat_ok + 32'(stat_ok != '1);
      else stat_err <= stat_err + 32'(stat_err != '1);
    end
  end
`endif
endmodule

// File: tb/tb_sig_output_formatter.sv
// tb_sig_output_formatter: directed self-checking bench for sig_output_formatter
module tb_sig_output_formatter;
  localparam logic [255:0] N    = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
  localparam logic [255:0] HALF = 256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_5D576E73_57A4501D_DFE92F46_681B20A0;
  localparam logic [255:0] V_EIP0 = 256'd22310257;
  localparam logic [255:0] V_EIP1 = 256'd22310258;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, eip155 = 0;
  logic [255:0] in_r = 0, in_s = 0, in_hash = 0;
  logic [1:0] in_recid = 0;
  logic in_ready, out_valid;
  logic [255:0] out_r, out_s, out_hash;
  logic [31:0] out_v;
  logic [2:0] out_err;
  logic [2:0] fifo_count;
`ifdef SIG_STATS_EN
  logic [31:0] stat_ok, stat_err;
`endif
  int checks = 0, failures = 0, good_pops = 0, bad_pops = 0;

  sig_output_formatter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_s(in_s), .in_recid(in_recid), .in_hash(in_hash), .eip155(eip155),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_s(out_s),
    .out_v(out_v), .out_hash(out_hash), .out_err(out_err), .fifo_count(fifo_count)
`ifdef SIG_STATS_EN
    , .stat_ok(stat_ok), .stat_err(stat_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [255:0] r, input logic [255:0] s, input logic [1:0] rc, input logic e, input logic [255:0] h);
    in_valid = 1; in_r = r; in_s = s; in_recid = rc; eip155 = e; in_hash = h;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    if (!in_ready) check("send_timeout", 0, 1);
    else @(posedge clk);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
  endtask

  task automatic pop_check(input string tag, input logic [255:0] r, input logic [255:0] s, input logic [255:0] v, input logic [2:0] err, input logic [255:0] h);
    check({tag, "_r"}, out_r, r);
    check({tag, "_s"}, out_s, s);
    check({tag, "_v"}, 256'(out_v), v);
    check({tag, "_err"}, 256'(out_err), 256'(err));
    check({tag, "_hash"}, out_hash, h);
    if (err == 0) good_pops++; else bad_pops++;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_in_ready", 256'(in_ready), 0);
    check("rst_out_valid", 256'(out_valid), 0);
    check("rst_count", 256'(fifo_count), 0);
    check("rst_out_r", out_r, 0);
    rst = 0;
    @(negedge clk);
    check("post_rst_ready", 256'(in_ready), 1);

    in_valid = 1; in_r = 1; in_s = 2; in_recid = 0; eip155 = 0; in_hash = 256'hABCD;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    check("busy_ready", 256'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      check("lat_early", 256'(out_valid), 0);
      @(negedge clk);
    end
    check("lat_rise", 256'(out_valid), 1);
    check("legacy_count", 256'(fifo_count), 1);
    pop_check("legacy", 1, 2, 27, 3'b000, 256'hABCD);
    check("legacy_drained", 256'(fifo_count), 0);

    send(7, N - 5, 0, 1, 256'h11);
    wait_valid("highs");
    pop_check("highs", 7, 5, V_EIP1, 3'b000, 256'h11);
    send(0, N, 3, 0, 256'h22);
    wait_valid("inval");
    pop_check("inval", 0, N, 28, 3'b111, 256'h22);
    send(N, HALF, 1, 1, 256'h33);
    wait_valid("rn_half");
    pop_check("rn_half", N, HALF, V_EIP1, 3'b001, 256'h33);
    send(N - 1, HALF + 1, 1, 0, 256'h44);
    wait_valid("half1");
    pop_check("half1", N - 1, HALF, 27, 3'b000, 256'h44);
    send(5, 0, 2, 1, 256'h55);
    wait_valid("s0");
    pop_check("s0", 5, 0, V_EIP0, 3'b110, 256'h55);

    for (int i = 0; i < 5; i++) send(256'(16 + i), 256'(i + 1), 0, 0, 256'(i));
    repeat (6) @(negedge clk);
    check("full_count", 256'(fifo_count), 4);
    check("full_stall_ready", 256'(in_ready), 0);
    check("full_head", out_r, 16);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    good_pops++;
    check("swap_count", 256'(fifo_count), 4);
    check("swap_head", out_r, 17);
    check("swap_ready", 256'(in_ready), 1);
    for (int i = 1; i < 5; i++) pop_check("order", 256'(16 + i), 256'(i + 1), 27, 3'b000, 256'(i));
    check("order_drained", 256'(fifo_count), 0);

    send(256'h30, 1, 0, 0, 0);
    send(256'h31, 1, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("pre_rst_count", 256'(fifo_count), 2);
    send(256'h32, 1, 0, 0, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("midrst_valid", 256'(out_valid), 0);
    check("midrst_count", 256'(fifo_count), 0);
    check("midrst_ready", 256'(in_ready), 0);
    rst = 0;
    good_pops = 0;
    bad_pops = 0;
    @(negedge clk);
    check("midrst_ready_after", 256'(in_ready), 1);
    check("midrst_still_empty", 256'(out_valid), 0);

    send(256'h40, 3, 0, 0, 1);
    wait_valid("st0");
    check("st0_count", 256'(fifo_count), 1);
    pop_check("st0", 256'h40, 3, 27, 3'b000, 1);
    send(256'h41, N - 1, 1, 0, 2);
    wait_valid("st1");
    pop_check("st1", 256'h41, 1, 27, 3'b000, 2);
    send(256'h42, 9, 1, 1, 3);
    wait_valid("st2");
    pop_check("st2", 256'h42, 9, V_EIP1, 3'b000, 3);
    send(0, 9, 0, 0, 4);
    wait_valid("st3");
    pop_check("st3", 0, 9, 27, 3'b001, 4);
    send(256'h43, N + 1, 0, 0, 5);
    wait_valid("st4");
    pop_check("st4", 256'h43, N + 1, 27, 3'b010, 5);
`ifdef SIG_STATS_EN
    check("stat_ok", 256'(stat_ok), 256'(good_pops));
    check("stat_err", 256'(stat_err), 256'(bad_pops));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
